ifu_top: RTL and testbench

IFU_TOP -- requirements
Module: ifu_top

---
 rtl/thetacore_pkg.sv | 25 ++
 rtl/ifu_top_if.sv | 36 +++
 rtl/ifu_pc_gen.sv | 28 ++
 rtl/ifu_top.sv | 159 +++++++++++++++
 tb/tb_ifu_top.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/thetacore_pkg.sv
// thetacore_pkg: shared types and constants for the instruction fetch unit.
//   fetch_state_e          - fetch sequencer states
//   RESET_PC_DEFAULT       - default first fetch address after reset
//   TIMEOUT_CYCLES_DEFAULT - default decoder-handshake wait budget
//   INSTR_W                - instruction / address width
//   is_misaligned()        - true when an address is not word aligned
package thetacore_pkg;

  localparam int          INSTR_W                = 32;
  localparam logic [31:0] RESET_PC_DEFAULT       = 32'h0000_0000;
  localparam int          TIMEOUT_CYCLES_DEFAULT = 16;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ     = 3'd1,
    S_PRESENT = 3'd2,
    S_RELEASE = 3'd3,
    S_HALT    = 3'd4
  } fetch_state_e;

  function automatic logic is_misaligned(input logic [INSTR_W-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/ifu_top_if.sv
// ifu_top_if: bundles the fetch unit's memory, decoder and control-unit signals.
//   master modport - the fetch unit (drives memory request, instruction, status)
//   slave modport  - the environment (memory, decoder, control unit)
interface ifu_top_if;
  import thetacore_pkg::*;

  logic               mem_req;
  logic [INSTR_W-1:0] mem_addr;
  logic               mem_rvalid;
  logic [INSTR_W-1:0] mem_rdata;
  logic [INSTR_W-1:0] instruction;
  logic               Fetch_ready;
  logic               IDU_ready;
  logic [INSTR_W-1:0] pc_increment;
  logic               redirect_valid;
  logic [INSTR_W-1:0] redirect_pc;
  logic               halt_req;
  logic [INSTR_W-1:0] pc;
  logic               halted;
  logic               fetch_misaligned;
  logic               idu_timeout;

  modport master (
    output mem_req, mem_addr, instruction, Fetch_ready, pc,
           halted, fetch_misaligned, idu_timeout,
    input  mem_rvalid, mem_rdata, IDU_ready, pc_increment,
           redirect_valid, redirect_pc, halt_req
  );

  modport slave (
    input  mem_req, mem_addr, instruction, Fetch_ready, pc,
           halted, fetch_misaligned, idu_timeout,
    output mem_rvalid, mem_rdata, IDU_ready, pc_increment,
           redirect_valid, redirect_pc, halt_req
  );
endinterface

// File: rtl/ifu_pc_gen.sv
// ifu_pc_gen: next-PC selection and alignment check.
//   pc_i, pc_increment_i      - sequential path: pc + increment (wraps)
//   redirect_valid_i/pc_i     - live redirect, highest priority
//   use_target_i/target_pc_i  - previously latched redirect target
//   next_pc_o, misaligned_o   - selected next PC and its alignment flag
module ifu_pc_gen
  import thetacore_pkg::*;
(
  input  logic [INSTR_W-1:0] pc_i,
  input  logic [INSTR_W-1:0] pc_increment_i,
  input  logic               redirect_valid_i,
  input  logic [INSTR_W-1:0] redirect_pc_i,
  input  logic               use_target_i,
  input  logic [INSTR_W-1:0] target_pc_i,
  output logic [INSTR_W-1:0] next_pc_o,
  output logic               misaligned_o
);

  // A live redirect beats a latched one so back-to-back redirects keep the newest.
  always_comb begin
    if (redirect_valid_i)  next_pc_o = redirect_pc_i;
    else if (use_target_i) next_pc_o = target_pc_i;
    else                   next_pc_o = pc_i + pc_increment_i;
  end

  assign misaligned_o = is_misaligned(next_pc_o);

endmodule

// File: rtl/ifu_top.sv
// ifu_top: instruction fetch sequencer.
//   soc_clk - system clock (rising edge)
//   reset   - asynchronous active-low reset
//   bus     - ifu_top_if.master: memory request/response, decoder handshake,
//             redirect/halt from the control unit, pc and sticky status flags
//
// state     | meaning
// S_IDLE    | first cycle after reset release
// S_REQ     | memory read outstanding at pc
// S_PRESENT | instruction held for the decoder, timeout counting down
// S_RELEASE | one-cycle Fetch_ready low, pc already advanced
// S_HALT    | stopped until reset
module ifu_top
  import thetacore_pkg::*;
#(
  parameter logic [INSTR_W-1:0] RESET_PC       = RESET_PC_DEFAULT,
  parameter int                 TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic        soc_clk,
  input  logic        reset,
  ifu_top_if.master   bus
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  fetch_state_e       state_q, state_d;
  logic [INSTR_W-1:0] pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [INSTR_W-1:0] target_q, target_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               kill_q, kill_d;
  logic               halt_pend_q, halt_pend_d;
  logic               misaligned_q, misaligned_d;
  logic               timeout_q, timeout_d;

  logic [INSTR_W-1:0] next_pc;
  logic               next_misaligned;

  ifu_pc_gen u_pc_gen (
    .pc_i             (pc_q),
    .pc_increment_i   (bus.pc_increment),
    .redirect_valid_i (bus.redirect_valid),
    .redirect_pc_i    (bus.redirect_pc),
    .use_target_i     (kill_q),
    .target_pc_i      (target_q),
    .next_pc_o        (next_pc),
    .misaligned_o     (next_misaligned)
  );

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    target_d     = target_q;
    cnt_d        = cnt_q;
    kill_d       = kill_q;
    halt_pend_d  = halt_pend_q;
    misaligned_d = misaligned_q;
    timeout_d    = timeout_q;

    case (state_q)
      S_IDLE, S_RELEASE: begin
        if (bus.halt_req) begin
          state_d = S_HALT;
        end else if (bus.redirect_valid && next_misaligned) begin
          misaligned_d = 1'b1;
          state_d      = S_HALT;
        end else begin
          if (bus.redirect_valid) pc_d = next_pc;
          state_d = S_REQ;
        end
      end

      S_REQ: begin
        // The read in flight must complete before anything changes mem_addr.
        if (bus.redirect_valid) begin
          target_d = bus.redirect_pc;
          kill_d   = 1'b1;
        end
        if (bus.halt_req) halt_pend_d = 1'b1;
        if (bus.mem_rvalid) begin
          kill_d      = 1'b0;
          halt_pend_d = 1'b0;
          if (bus.halt_req || halt_pend_q) begin
            state_d = S_HALT;
          end else if (kill_q || bus.redirect_valid) begin
            if (next_misaligned) begin
              misaligned_d = 1'b1;
              state_d      = S_HALT;
            end else begin
              pc_d = next_pc;
            end
          end else begin
            instr_d = bus.mem_rdata;
            cnt_d   = CNT_W'(TIMEOUT_CYCLES - 1);
            state_d = S_PRESENT;
          end
        end
      end

      S_PRESENT: begin
        if (bus.halt_req) begin
          state_d = S_HALT;
        end else if (bus.redirect_valid || bus.IDU_ready) begin
          if (next_misaligned) begin
            misaligned_d = 1'b1;
            state_d      = S_HALT;
          end else begin
            pc_d    = next_pc;
            state_d = S_RELEASE;
          end
        end else if (cnt_q == '0) begin
          timeout_d = 1'b1;
          state_d   = S_HALT;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_HALT: state_d = S_HALT;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge soc_clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      instr_q      <= '0;
      target_q     <= '0;
      cnt_q        <= '0;
      kill_q       <= 1'b0;
      halt_pend_q  <= 1'b0;
      misaligned_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      target_q     <= target_d;
      cnt_q        <= cnt_d;
      kill_q       <= kill_d;
      halt_pend_q  <= halt_pend_d;
      misaligned_q <= misaligned_d;
      timeout_q    <= timeout_d;
    end
  end

  assign bus.mem_req          = (state_q == S_REQ);
  assign bus.mem_addr         = pc_q;
  assign bus.instruction      = instr_q;
  assign bus.Fetch_ready      = (state_q == S_PRESENT);
  assign bus.pc               = pc_q;
  assign bus.halted           = (state_q == S_HALT);
  assign bus.fetch_misaligned = misaligned_q;
  assign bus.idu_timeout      = timeout_q;

endmodule

// File: tb/tb_ifu_top.sv
// tb_ifu_top: directed scenarios plus a randomized fetch stream checked
// against a transaction-level model of the fetch address sequence.
module tb_ifu_top;

  logic soc_clk = 1'b0;
  logic reset   = 1'b0;
  int   vectors     = 0;
  int   miscompares = 0;

  ifu_top_if bus ();

  ifu_top #(.RESET_PC(32'h0000_0000), .TIMEOUT_CYCLES(16)) dut (
    .soc_clk (soc_clk),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 soc_clk = ~soc_clk;

  logic [31:0] exp_pc, tgt, data, inc, rpc, nxt, held_instr;
  int          w, act;
  bit          kill;

  task automatic tick();
    @(posedge soc_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.mem_rvalid     = 1'b0;
    bus.mem_rdata      = '0;
    bus.IDU_ready      = 1'b0;
    bus.pc_increment   = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.halt_req       = 1'b0;
  endtask

  // Holds reset, checks the reset values, releases it; returns in the IDLE cycle.
  task automatic do_reset();
    idle_inputs();
    reset = 1'b0;
    tick();
    tick();
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_pc", bus.pc, 0);
    chk("rst_instr", bus.instruction, 0);
    chk("rst_fetch_ready", bus.Fetch_ready, 0);
    chk("rst_halted", bus.halted, 0);
    chk("rst_misaligned", bus.fetch_misaligned, 0);
    chk("rst_timeout", bus.idu_timeout, 0);
    reset = 1'b1;
    #1;
    chk("idle_mem_req", bus.mem_req, 0);
  endtask

  task automatic respond(input logic [31:0] d);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = d;
    tick();
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
  endtask

  initial begin
    // Reset, first fetch at 0 and presentation.
    do_reset();
    tick();
    chk("first_mem_req", bus.mem_req, 1);
    chk("first_mem_addr", bus.mem_addr, 32'h0);
    respond(32'h0050_0093);
    chk("first_fetch_ready", bus.Fetch_ready, 1);
    chk("first_instr", bus.instruction, 32'h0050_0093);
    chk("first_req_drop", bus.mem_req, 0);

    // Decoder accepts after 4 cycles, increment 4.
    repeat (3) begin
      tick();
      chk("present_hold", bus.Fetch_ready, 1);
    end
    bus.IDU_ready = 1'b1; bus.pc_increment = 32'd4;
    tick();
    bus.IDU_ready = 1'b0; bus.pc_increment = '0;
    chk("release_ready_low", bus.Fetch_ready, 0);
    chk("release_pc", bus.pc, 32'h4);
    tick();
    chk("second_mem_req", bus.mem_req, 1);
    chk("second_mem_addr", bus.mem_addr, 32'h4);
    chk("second_ready_low", bus.Fetch_ready, 0);

    // Redirect wins over simultaneous IDU_ready.
    respond(32'h0000_0013);
    bus.IDU_ready = 1'b1; bus.pc_increment = 32'd4;
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h100;
    tick();
    idle_inputs();
    chk("redir_pc", bus.pc, 32'h100);
    tick();
    chk("redir_mem_addr", bus.mem_addr, 32'h100);

    // Move to 8, then redirect to 0x40 while that read is outstanding.
    respond(32'h0010_0113);
    held_instr = 32'h0010_0113;
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h8;
    tick();
    idle_inputs();
    tick();
    chk("kill_req_addr", bus.mem_addr, 32'h8);
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h40;
    tick();
    idle_inputs();
    chk("kill_addr_stable", bus.mem_addr, 32'h8);
    chk("kill_req_stable", bus.mem_req, 1);
    tick();
    respond(32'hBAD0_0000);
    chk("kill_dropped", bus.Fetch_ready, 0);
    chk("kill_instr_kept", bus.instruction, held_instr);
    chk("kill_rereq", bus.mem_req, 1);
    chk("kill_new_addr", bus.mem_addr, 32'h40);

    // Randomized stream: model tracks the architectural fetch address sequence.
    exp_pc = 32'h40;
    for (int n = 0; n < 40; n++) begin
      chk("rnd_mem_req", bus.mem_req, 1);
      chk("rnd_mem_addr", bus.mem_addr, exp_pc);
      kill = 1'b0;
      w = $urandom_range(0, 3);
      for (int i = 0; i < w; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          tgt = $urandom & 32'hFFFF_FFFC;
          bus.redirect_valid = 1'b1; bus.redirect_pc = tgt;
          kill = 1'b1;
        end
        tick();
        bus.redirect_valid = 1'b0;
        chk("rnd_addr_stable", bus.mem_addr, exp_pc);
      end
      data = $urandom;
      respond(data);
      if (kill) begin
        chk("rnd_kill_drop", bus.Fetch_ready, 0);
        exp_pc = tgt;
        continue;
      end
      chk("rnd_ready", bus.Fetch_ready, 1);
      chk("rnd_instr", bus.instruction, data);
      chk("rnd_pc", bus.pc, exp_pc);
      w = $urandom_range(0, 5);
      for (int i = 0; i < w; i++) begin
        tick();
        chk("rnd_present_hold", bus.Fetch_ready, 1);
      end
      act = $urandom_range(0, 2);
      inc = $urandom & 32'hFFFF_FFFC;
      rpc = $urandom & 32'hFFFF_FFFC;
      nxt = (act != 0) ? rpc : exp_pc + inc;
      bus.IDU_ready      = (act != 1);
      bus.pc_increment   = inc;
      bus.redirect_valid = (act != 0);
      bus.redirect_pc    = rpc;
      tick();
      idle_inputs();
      chk("rnd_release_low", bus.Fetch_ready, 0);
      chk("rnd_release_pc", bus.pc, nxt);
      exp_pc = nxt;
      if ($urandom_range(0, 3) == 0) begin
        rpc = $urandom & 32'hFFFF_FFFC;
        bus.redirect_valid = 1'b1; bus.redirect_pc = rpc;
        exp_pc = rpc;
      end
      tick();
      idle_inputs();
    end

    // Misaligned next PC halts without moving pc.
    do_reset();
    tick();
    respond(32'h0050_0093);
    bus.IDU_ready = 1'b1; bus.pc_increment = 32'd6;
    tick();
    idle_inputs();
    chk("mis_flag", bus.fetch_misaligned, 1);
    chk("mis_halted", bus.halted, 1);
    chk("mis_pc", bus.pc, 32'h0);
    chk("mis_ready", bus.Fetch_ready, 0);
    chk("mis_timeout", bus.idu_timeout, 0);
    repeat (3) begin
      tick();
      chk("mis_no_req", bus.mem_req, 0);
      chk("mis_sticky", bus.halted, 1);
    end

    // Decoder silent for 16 PRESENT cycles.
    do_reset();
    tick();
    respond(32'h1234_5678);
    repeat (15) begin
      tick();
      chk("to_still_present", bus.Fetch_ready, 1);
      chk("to_not_halted", bus.halted, 0);
    end
    tick();
    chk("to_flag", bus.idu_timeout, 1);
    chk("to_halted", bus.halted, 1);
    chk("to_ready_low", bus.Fetch_ready, 0);
    chk("to_no_mis", bus.fetch_misaligned, 0);

    // Reset during REQ, then a stray mem_rvalid in IDLE.
    do_reset();
    tick();
    respond(32'h0050_0093);
    bus.IDU_ready = 1'b1; bus.pc_increment = 32'd4;
    tick();
    idle_inputs();
    tick();
    chk("mid_req_addr", bus.mem_addr, 32'h4);
    #2;
    reset = 1'b0;
    #1;
    chk("async_mem_req", bus.mem_req, 0);
    chk("async_mem_addr", bus.mem_addr, 32'h0);
    tick();
    reset = 1'b1;
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hDEAD_BEEF;
    tick();
    idle_inputs();
    chk("restart_req", bus.mem_req, 1);
    chk("restart_addr", bus.mem_addr, 32'h0);
    chk("stray_ignored", bus.Fetch_ready, 0);
    chk("stray_instr", bus.instruction, 32'h0);

    // halt_req in REQ waits for the outstanding response.
    bus.halt_req = 1'b1;
    tick();
    bus.halt_req = 1'b0;
    chk("halt_wait_req", bus.mem_req, 1);
    chk("halt_wait_flag", bus.halted, 0);
    tick();
    chk("halt_wait_req2", bus.mem_req, 1);
    respond(32'h0010_0073);
    chk("halt_done", bus.halted, 1);
    chk("halt_no_req", bus.mem_req, 0);
    chk("halt_ready_low", bus.Fetch_ready, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
